wb_stage_reg: RTL
=================

Name: wb_stage_reg

Overview:
- Parametrised MEM/WB pipeline register for the multi-issue core. It carries NUM_CH independent write-back channels from the memory stage to the register-file write port.
- Implements the stall-vector protocol: load, hold, or bubble-insert. Adds a flush input and write-after-write squash inside a bundle.
- Suppresses writes to register 0.
- Maintains a wrapping retired-instruction counter for the performance-counter unit.

Parameters:
- NUM_CH, 2, number of write-back channels per bundle (1..4).
- DATA_W, 32, write data width per channel.
- ADDR_W, 5, register address width per channel.
- STALL_W, 6, width of the stall vector.
- STAGE, 4, index of this stage in the stall vector; STAGE+1 is the downstream stage. Requires STAGE+1 < STALL_W.
- CNT_W, 32, retired-instruction counter width.
- ZERO_SUPPRESS, 1, when 1 a write to address 0 is never issued.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous reset, active-low (asserted when 0).
- stall  in  STALL_W  pipeline stall vector; 1 = Stop.
- flush  in  1  exception/redirect flush of this stage.
- mem_valid_i  in  NUM_CH  channel carries a real instruction.
- mem_we_i  in  NUM_CH  channel write enable.
- mem_waddr_i  in  NUM_CH*ADDR_W  destination addresses; channel k at [k*ADDR_W +: ADDR_W].
- mem_wdata_i  in  NUM_CH*DATA_W  write data; channel k at [k*DATA_W +: DATA_W].
- cnt_clr  in  1  synchronous clear of the retire counter.
- wb_valid_o  out  NUM_CH  registered valid.
- wb_we_o  out  NUM_CH  registered, qualified write enable.
- wb_waddr_o  out  NUM_CH*ADDR_W  registered addresses.
- wb_wdata_o  out  NUM_CH*DATA_W  registered data.
- retire_cnt_o  out  CNT_W  retired-instruction count.

Behaviour:
- Reset (rst=0, asynchronous): all outputs go to 0 immediately and stay 0 while rst=0. This includes retire_cnt_o.

Stage action, per rising edge, in priority order:
1. flush=1 → bubble. All valid, we, waddr and wdata registers are cleared to 0.
2. stall[STAGE]=1 and stall[STAGE+1]=0 → bubble, same clearing as flush.
3. stall[STAGE]=0 → load the qualified inputs.
4. Otherwise (both stall bits 1) → hold all registers unchanged.

Qualification on load, combinational before the registers:
- we_q[k] = mem_we_i[k] & mem_valid_i[k].
- If ZERO_SUPPRESS=1 and the address is 0, we_q[k] = 0.
- WAW squash: if channels j<k both have we_q=1 and equal addresses, we_q[j] is cleared. The highest-index channel wins.
- Valid, address and data are loaded unmodified, even for squashed channels.
- Latency: exactly 1 cycle from input to output on load. There is no combinational path from input to output.

Retire counter:
- Each edge: cnt_clr=1 sets the counter to 0, overriding any increment that cycle.
- Else, on a load edge with flush=0, add popcount(mem_valid_i) to the counter.
- Bubble and hold edges add nothing.
- The counter wraps modulo 2^CNT_W and never saturates.
- The increment uses the raw mem_valid_i. A squashed or zero-address instruction still counts as retired.

Boundary conditions:
- flush and a load in the same cycle: flush wins and the counter does not increment.
- cnt_clr during a hold: counter goes to 0 and the stage registers hold.
- Reset released mid-stall: the first edge after rst returns to 1 follows the normal priority rules.
- NUM_CH=1: the WAW logic degenerates to nothing.

Test Plan:
1. Reset then load: rst=0→1; stall=0, ch0 valid/we, addr=3, data=0xDEADBEEF; ch1 invalid. Next cycle: wb_we_o=2'b01, wb_waddr ch0=3, wb_wdata ch0=0xDEADBEEF, retire_cnt_o=1.
2. Stall handling: stall=6'b110000 holds the previous bundle for 3 cycles with unchanged outputs and count. Then stall=6'b010000 gives all outputs 0 on the next edge.
3. WAW and zero suppression:
   - Both channels valid/we, addr=7, data 0x11/0x22 → wb_we_o=2'b10, count +2.
   - ch0 addr=0 with we=1 → wb_we_o[0]=0, wb_valid_o[0]=1.
4. Flush priority: flush=1 with stall=0 and a 2-valid bundle → outputs 0 and counter unchanged. The next load with flush=0 increments by 2.
5. Counter wrap and clear: CNT_W=4, preload to 15, load 2 valid → 1. Assert cnt_clr together with a load → 0.
6. Asynchronous reset mid-operation: drive rst=0 between clock edges while outputs are nonzero. All outputs read 0 before the next edge.

Source files
------------

// File: rtl/wb_stage_reg.sv
// MEM/WB pipeline register carrying NUM_CH write-back channels into the
// register-file write port. The stall vector selects load, hold or bubble
// for each bundle, and flush forces a bubble. Write enables are qualified
// on the way in: invalid slots, writes to register 0 and write-after-write
// losers within a bundle never reach the register file. A wrapping
// retired-instruction counter feeds the performance-counter unit.
module wb_stage_reg #(
    parameter int NUM_CH        = 2,
    parameter int DATA_W        = 32,
    parameter int ADDR_W        = 5,
    parameter int STALL_W       = 6,
    parameter int STAGE         = 4,
    parameter int CNT_W         = 32,
    parameter int ZERO_SUPPRESS = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [STALL_W-1:0]       stall,
    input  logic                     flush,
    input  logic [NUM_CH-1:0]        mem_valid_i,
    input  logic [NUM_CH-1:0]        mem_we_i,
    input  logic [NUM_CH*ADDR_W-1:0] mem_waddr_i,
    input  logic [NUM_CH*DATA_W-1:0] mem_wdata_i,
    input  logic                     cnt_clr,
    output logic [NUM_CH-1:0]        wb_valid_o,
    output logic [NUM_CH-1:0]        wb_we_o,
    output logic [NUM_CH*ADDR_W-1:0] wb_waddr_o,
    output logic [NUM_CH*DATA_W-1:0] wb_wdata_o,
    output logic [CNT_W-1:0]         retire_cnt_o
);

    typedef enum logic [1:0] {
        ACT_LOAD,
        ACT_BUBBLE,
        ACT_HOLD
    } action_e;

    action_e             action;
    logic [NUM_CH-1:0]   we_raw;
    logic [NUM_CH-1:0]   we_q;
    logic [CNT_W-1:0]    retire_inc;

    // Decide what this edge does to the stage: flush beats stall, and a
    // stalled stage whose consumer is moving must emit a bubble.
    always_comb begin
        // NOTE: every variable written here gets a default first, so no path leaves it unassigned and no latch is inferred.
        action = ACT_HOLD;
        if (flush) begin
            action = ACT_BUBBLE;
        end else if (stall[STAGE] && !stall[STAGE+1]) begin
            action = ACT_BUBBLE;
        end else if (!stall[STAGE]) begin
            action = ACT_LOAD;
        end
    end

    // Qualify write enables: valid slot, non-zero target, last writer wins.
    always_comb begin
        we_raw = mem_we_i & mem_valid_i;
        if (ZERO_SUPPRESS != 0) begin
            for (int k = 0; k < NUM_CH; k++) begin
                if (mem_waddr_i[k*ADDR_W +: ADDR_W] == '0) begin
                    we_raw[k] = 1'b0;
                end
            end
        end
        we_q = we_raw;
        for (int j = 0; j < NUM_CH; j++) begin
            for (int k = j + 1; k < NUM_CH; k++) begin
                if (we_raw[j] && we_raw[k] &&
                    mem_waddr_i[j*ADDR_W +: ADDR_W] == mem_waddr_i[k*ADDR_W +: ADDR_W]) begin
                    we_q[j] = 1'b0;
                end
            end
        end
    end

    // Count every real instruction in the bundle, squashed or not.
    always_comb begin
        retire_inc = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            retire_inc = retire_inc + CNT_W'(mem_valid_i[k]);
        end
    end

    // Stage registers: load, bubble or hold the whole bundle.
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: the stage registers are few flops, so all of them take the async reset and the write port sees clean zeros at power-up.
        if (!rst) begin
            wb_valid_o <= '0;
            wb_we_o    <= '0;
            wb_waddr_o <= '0;
            wb_wdata_o <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            case (action)
                ACT_LOAD: begin
                    wb_valid_o <= mem_valid_i;
                    wb_we_o    <= we_q;
                    wb_waddr_o <= mem_waddr_i;
                    wb_wdata_o <= mem_wdata_i;
                end
                ACT_BUBBLE: begin
                    wb_valid_o <= '0;
                    wb_we_o    <= '0;
                    wb_waddr_o <= '0;
                    wb_wdata_o <= '0;
                end
                default: begin
                    wb_valid_o <= wb_valid_o;
                    wb_we_o    <= wb_we_o;
                    wb_waddr_o <= wb_waddr_o;
                    wb_wdata_o <= wb_wdata_o;
                end
            endcase
        end
    end

    // Retire counter: clear overrides, otherwise accumulate on load edges and wrap.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            retire_cnt_o <= '0;
        end else if (cnt_clr) begin
            retire_cnt_o <= '0;
        end else if (action == ACT_LOAD) begin
            retire_cnt_o <= retire_cnt_o + retire_inc;
        end
    end

endmodule
